// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the GCD job scheduler: state encoding, default data width
// and the width helper used to size requester ids and counters.
package gcd_sched_pkg;

    localparam int unsigned GCD_DW = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_BYPASS = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ISSUE  = ST_ISSUE,
        S_BYPASS = ST_BYPASS,
        S_WAIT   = ST_WAIT,
        S_RESP   = ST_RESP
    } sched_state_e;

    // Bits needed to encode values 0..n-1 (n >= 2 in this design).
    function automatic int unsigned gcd_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from
// the requester after last_grant, wrapping at N_REQ.
module gcd_rr_pick
    import gcd_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDW  = gcd_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic             any,
    output logic [IDW-1:0]   grant_id
);

    logic [IDW-1:0] idx;

    always_comb begin
        any      = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDW'((32'(last_grant) + 32'd1 + k) % N_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Round-robin scheduler sharing one GCD core among N_REQ requesters; zero operands
// are answered locally. Define GCD_TIMEOUT_EN to build the WAIT-state watchdog.
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DW             = GCD_DW,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDW           = gcd_clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    ack,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_d,
    output logic                rsp_err,
    output logic [DW-1:0]       gcd_a,
    output logic [DW-1:0]       gcd_b,
    output logic                gcd_start,
    input  logic                gcd_done,
    input  logic [DW-1:0]       gcd_d
);

    sched_state_e   state_q, state_nxt;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] id_q;
    logic [DW-1:0]  op_a_q, op_b_q;

    logic           pick_any;
    logic [IDW-1:0] pick_id;
    logic [DW-1:0]  win_a, win_b;
    logic           win_zero;
    logic           wd_expired;

    logic [N_REQ-1:0] ack_nxt;
    logic             gcd_start_nxt;
    logic             rsp_valid_nxt;
    logic [IDW-1:0]   rsp_id_nxt;
    logic [DW-1:0]    rsp_data_nxt;

    gcd_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req       (req),
        .last_grant(last_grant_q),
        .any       (pick_any),
        .grant_id  (pick_id)
    );

    assign win_a    = req_a[pick_id*DW +: DW];
    assign win_b    = req_b[pick_id*DW +: DW];
    assign win_zero = (win_a == '0) || (win_b == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_nxt     = state_q;
        ack_nxt       = '0;
        gcd_start_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = '0;
        rsp_data_nxt  = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    ack_nxt = N_REQ'(1) << pick_id;
                    if (win_zero) begin
                        state_nxt = S_BYPASS;
                    end else begin
                        state_nxt     = S_ISSUE;
                        gcd_start_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_BYPASS: begin
                // gcd(0,x) = x and gcd(0,0) = 0
                state_nxt     = S_RESP;
                rsp_valid_nxt = 1'b1;
                rsp_id_nxt    = id_q;
                rsp_data_nxt  = (op_a_q == '0) ? op_b_q : op_a_q;
            end
            S_WAIT: begin
                if (gcd_done) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = id_q;
                    rsp_data_nxt  = gcd_d;
                end else if (wd_expired) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = id_q;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Job registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= IDW'(N_REQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            ack          <= '0;
            gcd_start    <= 1'b0;
            gcd_a        <= '0;
            gcd_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_d        <= '0;
        end else begin
            ack       <= ack_nxt;
            gcd_start <= gcd_start_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_d     <= rsp_data_nxt;
            if (state_q == S_IDLE && pick_any) begin
                id_q   <= pick_id;
                op_a_q <= win_a;
                op_b_q <= win_b;
            end
            // Core operands only change when a new core job is issued
            if (gcd_start_nxt) begin
                gcd_a <= win_a;
                gcd_b <= win_b;
            end
            if (state_q == S_RESP) begin
                last_grant_q <= id_q;
            end
        end
    end

`ifdef GCD_TIMEOUT_EN
    localparam int unsigned TW = gcd_clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_q;

    assign wd_expired = (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles; held at zero outside WAIT so every entry starts clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            wd_cnt_q <= '0;
        end else if (!wd_expired) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= (state_q == S_WAIT) && !gcd_done && wd_expired;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model with a behavioural core.
module tb_gcd_job_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned TMO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    ack;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_d;
    logic            rsp_err;
    logic [DW-1:0]   gcd_a, gcd_b;
    logic            gcd_start;
    logic            gcd_done;
    logic [DW-1:0]   gcd_d;

    always #5 clk = ~clk;

    gcd_job_scheduler #(
        .N_REQ(N), .DW(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_d(rsp_d),
        .rsp_err(rsp_err), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
        .gcd_done(gcd_done), .gcd_d(gcd_d)
    );

    int checks = 0;
    int errors = 0;

    // Requester side of the model
    logic [N-1:0]  pending;
    logic [DW-1:0] pa [N];
    logic [DW-1:0] pb [N];
    bit            auto_repost;

    // Job timeline of the model, in cycle numbers
    int            cyc;
    bit            job_active;
    int            job_id;
    logic [DW-1:0] job_a, job_b;
    bit            job_bypass, job_err;
    int            ack_cyc, start_cyc, done_cyc, rsp_cyc, free_cyc;
    int            model_last;

    // Behavioural core controls
    int  k_fixed;
    bit  core_mute;

    int            start_count;
    int            rsp_log [$];
    int            d_log [$];
    int            err_log [$];
    int            posted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_result(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int predict_winner();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (model_last + 1 + k) % N;
            if (pending[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_op();
        return ($urandom_range(4) == 0) ? '0 : DW'($urandom);
    endfunction

    task automatic drive_reqs();
        req = pending;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = pa[i];
            req_b[i*DW +: DW] = pb[i];
        end
    endtask

    task automatic post_job(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        pa[id]      = a;
        pb[id]      = b;
        pending[id] = 1'b1;
        posted++;
        drive_reqs();
    endtask

    // One clock: decide acceptance from inputs in force at the edge, then check outputs.
    task automatic tick();
        int           w, k;
        logic [N-1:0] exp_ack;
        bit           exp_rsp, in_wait, ack_now;
        if (!job_active && cyc >= free_cyc && pending != '0) begin
            w          = predict_winner();
            job_active = 1'b1;
            job_id     = w;
            job_a      = pa[w];
            job_b      = pb[w];
            job_bypass = (job_a == '0) || (job_b == '0);
            job_err    = 1'b0;
            ack_cyc    = cyc + 1;
            start_cyc  = -1;
            done_cyc   = -1;
            rsp_cyc    = job_bypass ? cyc + 2 : -1;
            model_last = w;
        end
        @(posedge clk);
        #1;
        cyc++;
        ack_now = job_active && (cyc == ack_cyc);
        exp_ack = ack_now ? (N'(1) << job_id) : '0;
        check("ack", 32'(ack), 32'(exp_ack));
        check("gcd_start", 32'(gcd_start), 32'(ack_now && !job_bypass));
        if (gcd_start) start_count++;
        if (ack_now) begin
            if (auto_repost) begin
                pa[job_id] = rand_op();
                pb[job_id] = rand_op();
            end else begin
                pending[job_id] = 1'b0;
            end
            if (!job_bypass) begin
                check("gcd_a", 32'(gcd_a), 32'(job_a));
                check("gcd_b", 32'(gcd_b), 32'(job_b));
                start_cyc = cyc;
                if (core_mute) begin
`ifdef GCD_TIMEOUT_EN
                    rsp_cyc = cyc + TMO + 1;
                    job_err = 1'b1;
`else
                    rsp_cyc = -1;
`endif
                end else begin
                    k        = (k_fixed > 0) ? k_fixed : int'($urandom_range(10, 1));
                    done_cyc = cyc + k;
                    rsp_cyc  = done_cyc + 1;
                end
            end
        end
        exp_rsp = job_active && (cyc == rsp_cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp) begin
            check("rsp_id", 32'(rsp_id), 32'(job_id));
            check("rsp_d", 32'(rsp_d), job_err ? 32'd0 : 32'(exp_result(int'(job_a), int'(job_b))));
            check("rsp_err", 32'(rsp_err), 32'(job_err));
            rsp_log.push_back(int'(rsp_id));
            d_log.push_back(int'(rsp_d));
            err_log.push_back(int'(rsp_err));
            job_active = 1'b0;
            free_cyc   = cyc + 1;
        end
        // Core drive for this cycle; stray done pulses whenever the scheduler is not waiting
        in_wait = job_active && !job_bypass && (start_cyc >= 0) && (cyc > start_cyc);
        if (in_wait && cyc == done_cyc) begin
            gcd_done = 1'b1;
            gcd_d    = DW'(exp_result(int'(gcd_a), int'(gcd_b)));
        end else if (in_wait) begin
            gcd_done = 1'b0;
            gcd_d    = DW'($urandom);
        end else begin
            gcd_done = ($urandom_range(3) == 0);
            gcd_d    = DW'($urandom);
        end
        drive_reqs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((job_active || pending != '0) && n < budget) begin
            tick();
            n++;
        end
        check({"drain_", tag}, 32'(job_active || pending != '0), 32'd0);
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        d_log.delete();
        err_log.delete();
        start_count = 0;
        posted      = 0;
    endtask

    // Asserts reset away from the clock edge, checks outputs clear at once and stay clear.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_d", 32'(rsp_d), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_gcd_start", 32'(gcd_start), 32'd0);
        check("rst_gcd_a", 32'(gcd_a), 32'd0);
        check("rst_gcd_b", 32'(gcd_b), 32'd0);
        job_active = 1'b0;
        model_last = N - 1;
        gcd_done   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
            check("rst_hold", 32'({ack, rsp_valid, gcd_start}), 32'd0);
        end
        reset    = 1'b1;
        free_cyc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        pending     = '0;
        auto_repost = 1'b0;
        core_mute   = 1'b0;
        k_fixed     = 0;
        cyc         = 0;
        job_active  = 1'b0;
        free_cyc    = 0;
        model_last  = N - 1;
        gcd_done    = 1'b0;
        gcd_d       = '0;
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        drive_reqs();
        clear_logs();
        #2;
        apply_reset();

        // Single job through the core
        k_fixed = 3;
        post_job(0, 4'd15, 4'd5);
        drain("single", 30);
        check("single_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() == 1) begin
            check("single_id", 32'(rsp_log[0]), 32'd0);
            check("single_d", 32'(d_log[0]), 32'd5);
        end
        check("single_starts", 32'(start_count), 32'd1);

        // Two requests raised together
        apply_reset();
        clear_logs();
        k_fixed = 0;
        post_job(0, 4'd12, 4'd4);
        post_job(1, 4'd6, 4'd3);
        drain("contention", 60);
        check("cont_count", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) begin
            check("cont_id0", 32'(rsp_log[0]), 32'd0);
            check("cont_d0", 32'(d_log[0]), 32'd4);
            check("cont_id1", 32'(rsp_log[1]), 32'd1);
            check("cont_d1", 32'(d_log[1]), 32'd3);
        end
        check("cont_starts", 32'(start_count), 32'd2);

        // Zero operands answered locally
        clear_logs();
        post_job(0, 4'd0, 4'd9);
        drain("bypass_0_9", 10);
        post_job(0, 4'd0, 4'd0);
        drain("bypass_0_0", 10);
        post_job(0, 4'd7, 4'd0);
        drain("bypass_7_0", 10);
        check("byp_count", 32'(rsp_log.size()), 32'd3);
        if (rsp_log.size() == 3) begin
            check("byp_d0", 32'(d_log[0]), 32'd9);
            check("byp_d1", 32'(d_log[1]), 32'd0);
            check("byp_d2", 32'(d_log[2]), 32'd7);
        end
        check("byp_starts", 32'(start_count), 32'd0);

        // All requests held high
        apply_reset();
        clear_logs();
        auto_repost = 1'b1;
        for (int i = 0; i < N; i++) post_job(i, rand_op(), rand_op());
        n = 0;
        while (rsp_log.size() < 6 && n < 150) begin
            tick();
            n++;
        end
        check("fair_count", 32'(rsp_log.size() >= 6), 32'd1);
        if (rsp_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("fair_order", 32'(rsp_log[i]), 32'(i % N));
        end
        auto_repost = 1'b0;
        pending     = '0;
        drive_reqs();
        drain("fair", 30);

        // Reset while waiting on the core
        apply_reset();
        clear_logs();
        core_mute = 1'b1;
        post_job(2, 4'd9, 4'd6);
        repeat (6) tick();
        check("midwait_active", 32'(job_active), 32'd1);
        #2;
        apply_reset();
        core_mute = 1'b0;
        check("midwait_no_rsp", 32'(rsp_log.size()), 32'd0);
        for (int i = 0; i < N; i++) post_job(i, rand_op(), rand_op());
        drain("after_reset", 80);
        check("after_reset_count", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() > 0) check("after_reset_first", 32'(rsp_log[0]), 32'd0);

        // Core that never finishes
        apply_reset();
        clear_logs();
        core_mute = 1'b1;
        post_job(1, 4'd8, 4'd12);
`ifdef GCD_TIMEOUT_EN
        drain("timeout", 40);
        check("tmo_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() == 1) begin
            check("tmo_err", 32'(err_log[0]), 32'd1);
            check("tmo_d", 32'(d_log[0]), 32'd0);
        end
`else
        repeat (40) tick();
        check("stuck_no_rsp", 32'(rsp_log.size()), 32'd0);
        check("stuck_active", 32'(job_active), 32'd1);
`endif
        core_mute = 1'b0;
        #2;
        apply_reset();

        // Random traffic
        clear_logs();
        for (int it = 0; it < 500; it++) begin
            int id;
            if ($urandom_range(3) == 0) begin
                id = int'($urandom_range(N - 1));
                if (!pending[id]) post_job(id, rand_op(), rand_op());
            end
            tick();
        end
        drain("random", 400);
        check("rand_jobs", 32'(rsp_log.size()), 32'(posted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
